rs_station: RTL and testbench

Parametrised reservation station for one functional-unit class (add, mul or load) in the Tomasulo back end. It holds up to DEPTH dispatched operations and captures missing source operands by snooping the common data bus (CDB). It issues one fully ready operation per cycle to its functional unit over a valid/ready handshake. Each entry's identity on the CDB is UNIT_BASE + entry index, the same tag written into register result status at dispatch.

---
 rtl/rs_pkg.sv | 36 +++
 rtl/rs_select.sv | 63 ++++++
 rtl/rs_station.sv | 238 +++++++++++++++++++++++
 tb/tb_rs_station.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// -----------------------------------------------------------------------------
// rs_pkg
// Shared definitions for the Tomasulo reservation stations.
//   - default data/tag/opcode widths
//   - per-unit CDB tag bases (add, mul, load) and the "register valid" tag
//   - entry record type describing one reservation-station slot
// Optional build macro used by the station: RS_AGE_SEL_EN (oldest-first select).
// -----------------------------------------------------------------------------
package rs_pkg;

    localparam int RS_WORD_SIZE = 32;
    localparam int RS_TAG_SIZE  = 8;
    localparam int RS_OP_SIZE   = 4;
    localparam int RS_AGE_MAX_W = 5;    // enough for the largest supported DEPTH (32)

    // Tag of entry 0 for each functional-unit class.
    localparam logic [RS_TAG_SIZE-1:0] RS_ADD_BASE      = 8'h20;
    localparam logic [RS_TAG_SIZE-1:0] RS_MUL_BASE      = 8'h40;
    localparam logic [RS_TAG_SIZE-1:0] RS_LW_BASE       = 8'h80;
    // Register result status holds this tag when the architectural value is current.
    localparam logic [RS_TAG_SIZE-1:0] RS_REG_VALID_TAG = 8'h7F;

    // One reservation-station slot at the default widths.
    typedef struct packed {
        logic                     valid;
        logic [RS_OP_SIZE-1:0]    op;
        logic                     a_rdy;
        logic [RS_TAG_SIZE-1:0]   a_tag;
        logic [RS_WORD_SIZE-1:0]  a_val;
        logic                     b_rdy;
        logic [RS_TAG_SIZE-1:0]   b_tag;
        logic [RS_WORD_SIZE-1:0]  b_val;
        logic [RS_AGE_MAX_W-1:0]  age;
    } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// -----------------------------------------------------------------------------
// rs_select
// Issue arbiter for the reservation station.
//   ready  : one bit per entry, entry holds a fully ready operation
//   ages   : (RS_AGE_SEL_EN only) packed per-entry age, AW bits each,
//            0 = oldest; ages of valid entries are unique
//   grant  : one-hot winner
//   idx    : binary index of the winner (0 when nothing is ready)
//   any    : at least one entry is ready
// Build macro RS_AGE_SEL_EN: winner is the ready entry with minimum age;
// otherwise the lowest-index ready entry wins.
// -----------------------------------------------------------------------------
module rs_select #(
    parameter int DEPTH = 8,
    parameter int IW    = $clog2(DEPTH),
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]    ready,
`ifdef RS_AGE_SEL_EN
    input  logic [DEPTH*AW-1:0] ages,
`endif
    output logic [DEPTH-1:0]    grant,
    output logic [IW-1:0]       idx,
    output logic                any
);

    logic found;
`ifdef RS_AGE_SEL_EN
    logic [AW-1:0] best_age;

    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && (!found || (ages[i*AW +: AW] < best_age))) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IW'(i);
                best_age = ages[i*AW +: AW];
                found    = 1'b1;
            end
        end
        any = found;
    end
`else
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !found) begin
                grant[i] = 1'b1;
                idx      = IW'(i);
                found    = 1'b1;
            end
        end
        any = found;
    end
`endif

endmodule

// File: rtl/rs_station.sv
// -----------------------------------------------------------------------------
// rs_station
// Reservation station for one functional-unit class. Holds up to DEPTH
// dispatched operations, captures missing operands from the CDB and issues one
// fully ready operation per cycle over a valid/ready handshake.
// Entry i is known on the CDB as UNIT_BASE + i.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      synchronous squash of every entry
//   disp_valid / disp_ready    dispatch handshake (ready = a free entry exists)
//   disp_op, disp_{a,b}_rdy/_tag/_val   dispatched operation and operands
//   disp_tag                   tag the accepted dispatch receives
//   cdb_valid/_tag/_data       common data bus snoop
//   iss_valid / iss_ready      issue handshake to the functional unit
//   iss_op, iss_a, iss_b, iss_tag       issued operation
//   count                      number of occupied entries
//
// Build macro RS_AGE_SEL_EN: oldest-first issue select using a per-entry age;
// when undefined the lowest-index ready entry issues and no age is kept.
// -----------------------------------------------------------------------------
module rs_station
    import rs_pkg::*;
#(
    parameter int                    DEPTH     = 8,
    parameter int                    WORD_SIZE = RS_WORD_SIZE,
    parameter int                    TAG_SIZE  = RS_TAG_SIZE,
    parameter logic [TAG_SIZE-1:0]   UNIT_BASE = RS_ADD_BASE,
    parameter int                    OP_SIZE   = RS_OP_SIZE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [OP_SIZE-1:0]          disp_op,
    input  logic                        disp_a_rdy,
    input  logic                        disp_b_rdy,
    input  logic [TAG_SIZE-1:0]         disp_a_tag,
    input  logic [TAG_SIZE-1:0]         disp_b_tag,
    input  logic [WORD_SIZE-1:0]        disp_a_val,
    input  logic [WORD_SIZE-1:0]        disp_b_val,
    output logic [TAG_SIZE-1:0]         disp_tag,
    input  logic                        cdb_valid,
    input  logic [TAG_SIZE-1:0]         cdb_tag,
    input  logic [WORD_SIZE-1:0]        cdb_data,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output logic [OP_SIZE-1:0]          iss_op,
    output logic [WORD_SIZE-1:0]        iss_a,
    output logic [WORD_SIZE-1:0]        iss_b,
    output logic [TAG_SIZE-1:0]         iss_tag,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int IW = $clog2(DEPTH);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // ---------------------------------------------------------------- state
    logic [DEPTH-1:0]       valid_reg;
    logic [DEPTH-1:0]       a_rdy_reg;
    logic [DEPTH-1:0]       b_rdy_reg;
    logic [OP_SIZE-1:0]     op_reg    [DEPTH];
    logic [TAG_SIZE-1:0]    a_tag_reg [DEPTH];
    logic [TAG_SIZE-1:0]    b_tag_reg [DEPTH];
    logic [WORD_SIZE-1:0]   a_val_reg [DEPTH];
    logic [WORD_SIZE-1:0]   b_val_reg [DEPTH];
    logic [CW-1:0]          count_reg;

    // ------------------------------------------------------- per-entry view
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] a_wake;
    logic [DEPTH-1:0] b_wake;

    // Wakeup compares every CDB tag, including ones from other stations;
    // an entry never waits on its own tag so no self-filtering is needed.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign ready_vec[gi] = valid_reg[gi] & a_rdy_reg[gi] & b_rdy_reg[gi];
            assign a_wake[gi]    = cdb_valid & valid_reg[gi] & ~a_rdy_reg[gi]
                                   & (cdb_tag == a_tag_reg[gi]);
            assign b_wake[gi]    = cdb_valid & valid_reg[gi] & ~b_rdy_reg[gi]
                                   & (cdb_tag == b_tag_reg[gi]);
        end
    endgenerate

    // ----------------------------------------------------- free-slot finder
    logic [DEPTH-1:0] free_grant;
    logic [IW-1:0]    free_idx;
    logic             free_found;

    always_comb begin
        free_grant = '0;
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_reg[i] && !free_found) begin
                free_grant[i] = 1'b1;
                free_idx      = IW'(i);
                free_found    = 1'b1;
            end
        end
    end

    // -------------------------------------------------------- issue select
    logic [DEPTH-1:0] iss_grant;
    logic [IW-1:0]    iss_idx;

`ifdef RS_AGE_SEL_EN
    logic [AW-1:0]       age_reg [DEPTH];
    logic [DEPTH*AW-1:0] age_flat;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            assign age_flat[gi*AW +: AW] = age_reg[gi];
        end
    endgenerate
`endif

    rs_select #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .AW    (AW)
    ) u_select (
        .ready (ready_vec),
`ifdef RS_AGE_SEL_EN
        .ages  (age_flat),
`endif
        .grant (iss_grant),
        .idx   (iss_idx),
        .any   (iss_valid)
    );

    // ------------------------------------------------------------- outputs
    // Fullness comes from the registered count only, so an issue in the same
    // cycle never opens a slot for a same-cycle dispatch.
    assign disp_ready = (count_reg < CW'(DEPTH));
    assign disp_tag   = UNIT_BASE + TAG_SIZE'(free_idx);
    assign count      = count_reg;

    // Issue payload is forced to zero when nothing is issuable so the bus is
    // quiet after reset and between operations.
    assign iss_op  = iss_valid ? op_reg[iss_idx]    : '0;
    assign iss_a   = iss_valid ? a_val_reg[iss_idx] : '0;
    assign iss_b   = iss_valid ? b_val_reg[iss_idx] : '0;
    assign iss_tag = iss_valid ? (UNIT_BASE + TAG_SIZE'(iss_idx)) : '0;

    // ------------------------------------------------------ dispatch inputs
    logic                 do_disp;
    logic                 do_iss;
    logic                 a_byp;
    logic                 b_byp;
    logic                 new_a_rdy;
    logic                 new_b_rdy;
    logic [WORD_SIZE-1:0] new_a_val;
    logic [WORD_SIZE-1:0] new_b_val;

    assign do_disp = disp_valid & disp_ready & ~flush;
    assign do_iss  = iss_valid & iss_ready & ~flush;

    // An operand whose producer broadcasts in the dispatch cycle is captured
    // directly; otherwise it would miss the broadcast forever.
    assign a_byp     = ~disp_a_rdy & cdb_valid & (cdb_tag == disp_a_tag);
    assign b_byp     = ~disp_b_rdy & cdb_valid & (cdb_tag == disp_b_tag);
    assign new_a_rdy = disp_a_rdy | a_byp;
    assign new_b_rdy = disp_b_rdy | b_byp;
    assign new_a_val = a_byp ? cdb_data : disp_a_val;
    assign new_b_val = b_byp ? cdb_data : disp_b_val;

    // ------------------------------------------------------- entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            a_rdy_reg <= '0;
            b_rdy_reg <= '0;
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_reg[i]    <= '0;
                a_tag_reg[i] <= '0;
                b_tag_reg[i] <= '0;
                a_val_reg[i] <= '0;
                b_val_reg[i] <= '0;
            end
        end else if (flush) begin
            valid_reg <= '0;
            count_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (a_wake[i]) begin
                    a_rdy_reg[i] <= 1'b1;
                    a_val_reg[i] <= cdb_data;
                end
                if (b_wake[i]) begin
                    b_rdy_reg[i] <= 1'b1;
                    b_val_reg[i] <= cdb_data;
                end
                if (do_iss && iss_grant[i]) begin
                    valid_reg[i] <= 1'b0;
                end
                // The free slot is never valid, so this cannot collide with
                // the wakeup or issue updates above.
                if (do_disp && free_grant[i]) begin
                    valid_reg[i] <= 1'b1;
                    op_reg[i]    <= disp_op;
                    a_rdy_reg[i] <= new_a_rdy;
                    a_tag_reg[i] <= disp_a_tag;
                    a_val_reg[i] <= new_a_val;
                    b_rdy_reg[i] <= new_b_rdy;
                    b_tag_reg[i] <= disp_b_tag;
                    b_val_reg[i] <= new_b_val;
                end
            end
            count_reg <= count_reg + CW'(do_disp) - CW'(do_iss);
        end
    end

`ifdef RS_AGE_SEL_EN
    // Age = number of older valid entries. A newcomer is younger than every
    // survivor; when an entry issues, everything younger moves up by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_reg[i] <= '0;
            end
        end else if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_disp && free_grant[i]) begin
                    age_reg[i] <= AW'(count_reg - CW'(do_iss));
                end else if (do_iss && valid_reg[i] && (age_reg[i] > age_reg[iss_idx])) begin
                    age_reg[i] <= age_reg[i] - AW'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rs_station.sv
// -----------------------------------------------------------------------------
// tb_rs_station
// Directed bench for rs_station (DEPTH=8, UNIT_BASE=8'h20). Stimulus pushes the
// expected issue record into a queue; a monitor on the falling edge pops and
// compares whenever an issue handshake is presented. Status outputs are
// checked directly one step after the relevant clock edge.
// -----------------------------------------------------------------------------
module tb_rs_station;

    localparam int DEPTH = 8;
    localparam int W     = 32;
    localparam int T     = 8;
    localparam int OPW   = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           flush;
    logic           disp_valid;
    logic           disp_ready;
    logic [OPW-1:0] disp_op;
    logic           disp_a_rdy, disp_b_rdy;
    logic [T-1:0]   disp_a_tag, disp_b_tag;
    logic [W-1:0]   disp_a_val, disp_b_val;
    logic [T-1:0]   disp_tag;
    logic           cdb_valid;
    logic [T-1:0]   cdb_tag;
    logic [W-1:0]   cdb_data;
    logic           iss_valid;
    logic           iss_ready;
    logic [OPW-1:0] iss_op;
    logic [W-1:0]   iss_a, iss_b;
    logic [T-1:0]   iss_tag;
    logic [CW-1:0]  count;

    rs_station #(
        .DEPTH     (DEPTH),
        .WORD_SIZE (W),
        .TAG_SIZE  (T),
        .UNIT_BASE (8'h20),
        .OP_SIZE   (OPW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_op    (disp_op),
        .disp_a_rdy (disp_a_rdy),
        .disp_b_rdy (disp_b_rdy),
        .disp_a_tag (disp_a_tag),
        .disp_b_tag (disp_b_tag),
        .disp_a_val (disp_a_val),
        .disp_b_val (disp_b_val),
        .disp_tag   (disp_tag),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_op     (iss_op),
        .iss_a      (iss_a),
        .iss_b      (iss_b),
        .iss_tag    (iss_tag),
        .count      (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [T-1:0]   tag;
        logic [OPW-1:0] op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic push(input logic [T-1:0] tag, input logic [OPW-1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.tag = tag; e.op = op; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic disp(input logic [OPW-1:0] op,
                        input logic ar, input logic [T-1:0] at, input logic [W-1:0] av,
                        input logic br, input logic [T-1:0] bt, input logic [W-1:0] bv);
        disp_valid = 1'b1;
        disp_op    = op;
        disp_a_rdy = ar; disp_a_tag = at; disp_a_val = av;
        disp_b_rdy = br; disp_b_tag = bt; disp_b_val = bv;
    endtask

    task automatic cdb(input logic [T-1:0] tag, input logic [W-1:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    // Scoreboard monitor: the handshake seen at the falling edge completes at
    // the next rising edge, since inputs only change just after rising edges.
    always @(negedge clk) begin
        if (rst_n && iss_valid && iss_ready) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL issue: unexpected tag=%h op=%h a=%h b=%h", iss_tag, iss_op, iss_a, iss_b);
            end else begin
                e = exp_q.pop_front();
                if (iss_tag !== e.tag || iss_op !== e.op || iss_a !== e.a || iss_b !== e.b) begin
                    errors++;
                    $display("FAIL issue: got tag=%h op=%h a=%h b=%h, want tag=%h op=%h a=%h b=%h",
                             iss_tag, iss_op, iss_a, iss_b, e.tag, e.op, e.a, e.b);
                end else begin
                    $display("ok   issue: tag=%h op=%h a=%h b=%h", iss_tag, iss_op, iss_a, iss_b);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        iss_ready = 1'b0;
        disp_op = '0; disp_a_rdy = 1'b0; disp_b_rdy = 1'b0;
        disp_a_tag = '0; disp_b_tag = '0; disp_a_val = '0; disp_b_val = '0;
        cdb_tag = '0; cdb_data = '0;
        idle();
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_count",      32'(count),     0);
        chk("rst_iss_valid",  32'(iss_valid), 0);
        chk("rst_disp_ready", 32'(disp_ready), 1);
        chk("rst_disp_tag",   32'(disp_tag),  32'h20);
        chk("rst_iss_tag",    32'(iss_tag),   0);
        chk("rst_iss_a",      iss_a,          0);

        // Both operands ready: issue one cycle after dispatch
        iss_ready = 1'b1;
        disp(4'h1, 1'b1, 8'h00, 32'd5, 1'b1, 8'h00, 32'd7);
        push(8'h20, 4'h1, 32'd5, 32'd7);
        tick(); idle();
        chk("ready_lat_valid", 32'(iss_valid), 1);
        tick();
        chk("ready_drained", 32'(count), 0);

        // Operand a waits on tag 41; CDB delivers it two cycles later
        disp(4'h2, 1'b0, 8'h41, 32'd0, 1'b1, 8'h00, 32'd3);
        tick(); idle();
        chk("wait_valid0", 32'(iss_valid), 0);
        tick();
        chk("wait_valid1", 32'(iss_valid), 0);
        cdb(8'h41, 32'hDEAD);
        push(8'h20, 4'h2, 32'hDEAD, 32'd3);
        tick(); idle();
        chk("wake_valid", 32'(iss_valid), 1);
        tick();

        // Dispatch-cycle CDB bypass
        disp(4'h3, 1'b0, 8'h42, 32'd0, 1'b1, 8'h00, 32'd4);
        cdb(8'h42, 32'd9);
        push(8'h20, 4'h3, 32'd9, 32'd4);
        tick(); idle();
        chk("byp_valid", 32'(iss_valid), 1);
        tick();
        chk("byp_drained", 32'(count), 0);

        // Fill all entries with waiting operations
        iss_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("fill_tag%0d", i), 32'(disp_tag), 32'h20 + i);
            disp(OPW'(i), 1'b0, 8'h50 + T'(i), 32'd0, 1'b1, 8'h00, 32'h100 + i);
            tick();
        end
        idle();
        chk("full_count",      32'(count),      8);
        chk("full_disp_ready", 32'(disp_ready), 0);
        chk("full_iss_valid",  32'(iss_valid),  0);
        // Wake entry 5 and issue it
        cdb(8'h55, 32'h555);
        tick(); idle();
        push(8'h25, 4'h5, 32'h555, 32'h105);
        iss_ready = 1'b1;
        chk("full_ready_same_cycle", 32'(disp_ready), 0);
        tick();
        iss_ready = 1'b0;
        chk("freed_disp_ready", 32'(disp_ready), 1);
        chk("freed_count",      32'(count),      7);
        chk("freed_disp_tag",   32'(disp_tag),   32'h25);

        // Flush squashes everything, including a same-cycle ready dispatch
        flush = 1'b1;
        disp(4'h9, 1'b1, 8'h00, 32'd1, 1'b1, 8'h00, 32'd2);
        tick(); idle();
        chk("flush_count",     32'(count),     0);
        chk("flush_iss_valid", 32'(iss_valid), 0);

        // Age: entry 3 becomes older than a re-dispatched entry 1
        for (int i = 0; i < 4; i++) begin
            disp(OPW'(10 + i), 1'b0, 8'h60 + T'(i), 32'd0, 1'b1, 8'h00, 32'hB0 + i);
            tick();
        end
        idle();
        cdb(8'h61, 32'h11);
        tick(); idle();
        push(8'h21, 4'd11, 32'h11, 32'hB1);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        chk("age_disp_tag", 32'(disp_tag), 32'h21);
        disp(4'd14, 1'b1, 8'h00, 32'h14, 1'b1, 8'h00, 32'h15);
        cdb(8'h63, 32'h33);
        tick(); idle();
        chk("age_count4", 32'(count), 4);
`ifdef RS_AGE_SEL_EN
        push(8'h23, 4'd13, 32'h33, 32'hB3);
        push(8'h21, 4'd14, 32'h14, 32'h15);
`else
        push(8'h21, 4'd14, 32'h14, 32'h15);
        push(8'h23, 4'd13, 32'h33, 32'hB3);
`endif
        iss_ready = 1'b1;
        tick(); tick();
        iss_ready = 1'b0;
        chk("age_count2", 32'(count), 2);

        // Asynchronous reset with three entries valid
        disp(4'd15, 1'b0, 8'h70, 32'd0, 1'b0, 8'h71, 32'd0);
        tick(); idle();
        chk("pre_rst_count", 32'(count), 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count",      32'(count),      0);
        chk("mid_rst_iss_valid",  32'(iss_valid),  0);
        chk("mid_rst_disp_ready", 32'(disp_ready), 1);
        chk("mid_rst_disp_tag",   32'(disp_tag),   32'h20);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_count", 32'(count), 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
